p6_controller: RTL

Multicycle control unit for the simple RISC machine. It owns the program counter (PC), the instruction register (IR) and the data-address register, and fetches 16-bit instructions from unified memory. It decodes each instruction and drives the register-file, pipeline-register, mux and ALU controls of `p6_datapath` one state per cycle. It sits between memory and the datapath and is the only block that sequences the datapath.

---
 rtl/p6_controller_if.sv | 28 ++
 rtl/p6_controller.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p6_controller_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : p6_controller_if                                            |
// | Brief   : Unified-memory bus between the p6 controller and memory.    |
// |           Command/address flow from the controller; the read word     |
// |           returns one cycle after a READ command.                     |
// | Rev     : 1.0                                                         |
// +-----------------------------------------------------------------------+
interface p6_controller_if #(
   parameter int ADDR_W = 9
) ();
   logic [1:0]        mem_cmd;    // 00 NONE, 01 READ, 10 WRITE
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_rdata;

   modport master (
      output mem_cmd,
      output mem_addr,
      input  mem_rdata
   );

   modport slave (
      input  mem_cmd,
      input  mem_addr,
      output mem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/p6_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : p6_controller                                               |
// | Brief   : Multicycle control unit for the simple RISC machine. Owns   |
// |           PC, IR and the data-address register, fetches from unified  |
// |           memory and sequences p6_datapath one state per cycle.       |
// | Rev     : 1.0                                                         |
// +-----------------------------------------------------------------------+
module p6_controller #(
   parameter int ADDR_W   = 9,
   parameter int RESET_PC = 0
) (
   input  wire               clk,
   input  wire               reset_n,
   p6_controller_if.master   mem,
   input  wire  [15:0]       datapath_out,
   input  wire               N_in,
   input  wire               V_in,
   input  wire               Z_in,
   output logic [2:0]        readnum,
   output logic [2:0]        writenum,
   output logic              write,
   output logic              loada,
   output logic              loadb,
   output logic              loadc,
   output logic              loads,
   output logic              asel,
   output logic              bsel,
   output logic [1:0]        vsel,
   output logic [1:0]        shift,
   output logic [1:0]        ALUop,
   output logic [15:0]       sximm5,
   output logic [15:0]       sximm8,
   output logic [15:0]       PC,
   output logic              halted
);

   localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);
   localparam logic [ADDR_W-1:0] c_pc_one   = ADDR_W'(1);

   localparam logic [1:0] c_cmd_none  = 2'b00;
   localparam logic [1:0] c_cmd_read  = 2'b01;
   localparam logic [1:0] c_cmd_write = 2'b10;

   typedef enum logic [4:0] {
      S_RST     = 5'd0,
      S_FETCH   = 5'd1,
      S_LOAD_IR = 5'd2,
      S_DECODE  = 5'd3,
      S_GET_A   = 5'd4,
      S_GET_B   = 5'd5,
      S_EXEC    = 5'd6,
      S_WR_REG  = 5'd7,
      S_WR_IMM  = 5'd8,
      S_ADDR    = 5'd9,
      S_LATCH   = 5'd10,
      S_MEM_RD  = 5'd11,
      S_MEM_WB  = 5'd12,
      S_PASS    = 5'd13,
      S_MEM_WR  = 5'd14,
      S_LINK    = 5'd15,
      S_BRANCH  = 5'd16,
      S_SET_PC  = 5'd17,
      S_HALT    = 5'd18
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [ADDR_W-1:0] r_pc;
   logic [15:0]       r_ir;
   logic [ADDR_W-1:0] r_daddr;

   logic [2:0]        w_opcode;
   logic [1:0]        w_op;
   logic [2:0]        w_rn;
   logic [2:0]        w_rd;
   logic [1:0]        w_sh;
   logic [2:0]        w_rm;
   logic [2:0]        w_cond;
   logic              w_cond_true;
   logic              w_take_branch;
   logic              w_is_cmp;
   logic              w_is_str;
   logic              w_is_bx;
   logic              w_b_from_rd;
   logic [1:0]        w_mem_cmd;
   logic [ADDR_W-1:0] w_mem_addr;

   // Instruction fields
   assign w_opcode = r_ir[15:13];
   assign w_op     = r_ir[12:11];
   assign w_rn     = r_ir[10:8];
   assign w_rd     = r_ir[7:5];
   assign w_sh     = r_ir[4:3];
   assign w_rm     = r_ir[2:0];
   assign w_cond   = r_ir[10:8];

   assign w_is_cmp    = (w_opcode == 3'b101) && (w_op == 2'b01);
   assign w_is_str    = (w_opcode == 3'b100);
   assign w_is_bx     = (w_opcode == 3'b010);
   // STR and BX read their second operand from the Rd field, not Rm
   assign w_b_from_rd = w_is_str || w_is_bx;

   assign sximm5 = {{11{r_ir[4]}}, r_ir[4:0]};
   assign sximm8 = {{8{r_ir[7]}},  r_ir[7:0]};

   assign mem.mem_cmd  = w_mem_cmd;
   assign mem.mem_addr = w_mem_addr;

   generate
      if (ADDR_W < 16) begin : g_pc_narrow
         logic w_unused_dp;
         assign PC          = {{(16-ADDR_W){1'b0}}, r_pc};
         assign w_unused_dp = &{1'b0, datapath_out[15:ADDR_W]};
      end else begin : g_pc_full
         assign PC = r_pc;
      end
   endgenerate

   // Branch condition evaluated against the flags latched by the last CMP
   always_comb begin
      w_cond_true = 1'b0;
      case (w_cond)
         3'b000:  w_cond_true = 1'b1;
         3'b001:  w_cond_true = Z_in;
         3'b010:  w_cond_true = ~Z_in;
         3'b011:  w_cond_true = N_in ^ V_in;
         3'b100:  w_cond_true = (N_in ^ V_in) | Z_in;
         default: w_cond_true = 1'b0;
      endcase
   end

   // BL reaches BRANCH through LINK and is always taken
   assign w_take_branch = (w_opcode == 3'b010) || w_cond_true;

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_RST;
      end else begin
         r_state <= w_next_state;
      end
   end

   // PC, IR and data-address registers, updated only in their owning states
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pc    <= c_reset_pc;
         r_ir    <= 16'h0000;
         r_daddr <= '0;
      end else begin
         case (r_state)
            S_LOAD_IR: begin
               r_ir <= mem.mem_rdata;
               r_pc <= r_pc + c_pc_one;
            end
            S_LATCH: begin
               r_daddr <= datapath_out[ADDR_W-1:0];
            end
            S_BRANCH: begin
               if (w_take_branch) begin
                  r_pc <= r_pc + sximm8[ADDR_W-1:0];
               end
            end
            S_SET_PC: begin
               r_pc <= datapath_out[ADDR_W-1:0];
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state and per-state datapath/memory controls
   always_comb begin
      w_next_state = r_state;
      w_mem_cmd    = c_cmd_none;
      w_mem_addr   = '0;
      readnum      = 3'd0;
      writenum     = 3'd0;
      write        = 1'b0;
      loada        = 1'b0;
      loadb        = 1'b0;
      loadc        = 1'b0;
      loads        = 1'b0;
      asel         = 1'b0;
      bsel         = 1'b0;
      vsel         = 2'b00;
      shift        = 2'b00;
      ALUop        = 2'b00;
      halted       = 1'b0;

      case (r_state)
         S_RST: begin
            w_next_state = S_FETCH;
         end
         S_FETCH: begin
            w_mem_cmd    = c_cmd_read;
            w_mem_addr   = r_pc;
            w_next_state = S_LOAD_IR;
         end
         S_LOAD_IR: begin
            w_next_state = S_DECODE;
         end
         S_DECODE: begin
            case (w_opcode)
               3'b110: begin
                  if (w_op == 2'b10)      w_next_state = S_WR_IMM;
                  else if (w_op == 2'b00) w_next_state = S_GET_B;
                  else                    w_next_state = S_FETCH;
               end
               3'b101: begin
                  // MVN has no A operand; the rest read Rn first
                  w_next_state = (w_op == 2'b11) ? S_GET_B : S_GET_A;
               end
               3'b011, 3'b100: begin
                  w_next_state = (w_op == 2'b00) ? S_GET_A : S_FETCH;
               end
               3'b001: begin
                  w_next_state = S_BRANCH;
               end
               3'b010: begin
                  if (w_op == 2'b11)      w_next_state = S_LINK;
                  else if (w_op == 2'b00) w_next_state = S_GET_B;
                  else                    w_next_state = S_FETCH;
               end
               3'b111: begin
                  w_next_state = S_HALT;
               end
               default: begin
                  w_next_state = S_FETCH;
               end
            endcase
         end
         S_GET_A: begin
            readnum      = w_rn;
            loada        = 1'b1;
            w_next_state = (w_opcode == 3'b101) ? S_GET_B : S_ADDR;
         end
         S_GET_B: begin
            readnum      = w_b_from_rd ? w_rd : w_rm;
            loadb        = 1'b1;
            w_next_state = w_b_from_rd ? S_PASS : S_EXEC;
         end
         S_EXEC: begin
            // MOV reg computes 0 + shifted B
            asel         = (w_opcode == 3'b110);
            shift        = w_sh;
            ALUop        = w_op;
            loadc        = 1'b1;
            loads        = w_is_cmp;
            w_next_state = w_is_cmp ? S_FETCH : S_WR_REG;
         end
         S_WR_REG: begin
            writenum     = w_rd;
            vsel         = 2'b00;
            write        = 1'b1;
            w_next_state = S_FETCH;
         end
         S_WR_IMM: begin
            writenum     = w_rn;
            vsel         = 2'b01;
            write        = 1'b1;
            w_next_state = S_FETCH;
         end
         S_ADDR: begin
            bsel         = 1'b1;
            ALUop        = 2'b00;
            loadc        = 1'b1;
            w_next_state = S_LATCH;
         end
         S_LATCH: begin
            w_next_state = w_is_str ? S_GET_B : S_MEM_RD;
         end
         S_MEM_RD: begin
            w_mem_cmd    = c_cmd_read;
            w_mem_addr   = r_daddr;
            w_next_state = S_MEM_WB;
         end
         S_MEM_WB: begin
            writenum     = w_rd;
            vsel         = 2'b10;
            write        = 1'b1;
            w_next_state = S_FETCH;
         end
         S_PASS: begin
            asel         = 1'b1;
            shift        = 2'b00;
            ALUop        = 2'b00;
            loadc        = 1'b1;
            w_next_state = w_is_str ? S_MEM_WR : S_SET_PC;
         end
         S_MEM_WR: begin
            w_mem_cmd    = c_cmd_write;
            w_mem_addr   = r_daddr;
            w_next_state = S_FETCH;
         end
         S_LINK: begin
            writenum     = 3'd7;
            vsel         = 2'b11;
            write        = 1'b1;
            w_next_state = S_BRANCH;
         end
         S_BRANCH: begin
            w_next_state = S_FETCH;
         end
         S_SET_PC: begin
            w_next_state = S_FETCH;
         end
         S_HALT: begin
            halted       = 1'b1;
            w_next_state = S_HALT;
         end
         default: begin
            w_next_state = S_RST;
         end
      endcase
   end

endmodule
`default_nettype wire
